// File: rtl/awg_pkg.sv
// Shared encodings, configuration layout and reset constants for the
// multi-channel DDS waveform generator.
package awg_pkg;

    typedef enum logic [2:0] {
        MODE_OFF   = 3'd0,
        MODE_SAW   = 3'd1,
        MODE_TRI   = 3'd2,
        MODE_SQR   = 3'd3,
        MODE_SIN   = 3'd4,
        MODE_NOISE = 3'd5
    } mode_e;

    localparam logic [2:0] ADDR_MODE = 3'd0;
    localparam logic [2:0] ADDR_FTW  = 3'd1;
    localparam logic [2:0] ADDR_POFF = 3'd2;
    localparam logic [2:0] ADDR_GAIN = 3'd3;
    localparam logic [2:0] ADDR_DUTY = 3'd4;

    localparam logic [7:0]  GAIN_UNITY = 8'd128;
    localparam logic [15:0] DUTY_RST   = 16'h8000;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    // taps 16,14,13,11 -> bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

    typedef struct packed {
        logic [2:0]  mode;
        logic [31:0] ftw;
        logic [15:0] poff;
        logic [7:0]  gain;
        logic [15:0] duty;
    } ch_cfg_t;

    localparam ch_cfg_t CFG_RST = '{mode: 3'd0, ftw: 32'd0, poff: 16'd0,
                                    gain: GAIN_UNITY, duty: DUTY_RST};

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], ^(l & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sin_lut.sv
// Quarter-wave sine ROM with one-cycle registered read. Contents are
// generated at elaboration from a fixed-point Taylor series.
module sin_lut #(
    parameter int LUT_AW = 10,
    parameter int DAC_W  = 14
) (
    input  logic              clk,
    input  logic [LUT_AW-1:0] addr,
    output logic [DAC_W-2:0]  data
);

    // Sample at the centre of each step so the mirrored quadrant lines up.
    function automatic int sine_val(input int i);
        longint x, x2, term, sum;
        x    = (longint'(2 * i + 1) * 64'sd1686629713) / longint'(2 ** (LUT_AW + 1));
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (int k = 1; k <= 6; k++) begin
            term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        return int'((sum * longint'(2 ** (DAC_W - 1) - 1) + (64'sd1 <<< 29)) >>> 30);
    endfunction

    logic [DAC_W-2:0] rom [2**LUT_AW];

    for (genvar i = 0; i < 2**LUT_AW; i++) begin : g_rom
        localparam logic [DAC_W-2:0] V = (DAC_W-1)'(sine_val(i));
        assign rom[i] = V;
    end

    always_ff @(posedge clk) data <= rom[addr];

endmodule

// File: rtl/awg_multich.sv
// N_CH-channel DDS generator: shared double-buffered config, per-channel
// accumulator, waveform select, gain and saturation in a 3-stage pipeline.
module awg_multich
    import awg_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int DAC_W   = 14,
    parameter int PHASE_W = 32,
    parameter int LUT_AW  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [2:0]            cfg_ch,
    input  logic [2:0]            cfg_addr,
    input  logic [31:0]           cfg_data,
    input  logic                  commit,
    input  logic                  sync,
    output logic [N_CH*DAC_W-1:0] dac_data,
    output logic                  dac_valid,
    output logic                  dac_clk,
    output logic                  dac_wr
);

    localparam int STAGES = 3;
    localparam logic [DAC_W-1:0] MID = {1'b1, {(DAC_W-1){1'b0}}};
    localparam logic signed [DAC_W+8:0] Y_MAX = (DAC_W+9)'((1 <<< (DAC_W-1)) - 1);
    localparam logic signed [DAC_W+8:0] Y_MIN = -Y_MAX - 1;

    ch_cfg_t [N_CH-1:0] shadow, shadow_nxt, active;
    logic [STAGES:0]    vld_pipe;

    // Channels >= N_CH never match, so out-of-range writes fall away.
    always_comb begin
        shadow_nxt = shadow;
        for (int k = 0; k < N_CH; k++) begin
            if (cfg_we && cfg_ch == 3'(k)) begin
                case (cfg_addr)
                    ADDR_MODE: shadow_nxt[k].mode = cfg_data[2:0];
                    ADDR_FTW:  shadow_nxt[k].ftw  = cfg_data;
                    ADDR_POFF: shadow_nxt[k].poff = cfg_data[15:0];
                    ADDR_GAIN: shadow_nxt[k].gain = cfg_data[7:0];
                    ADDR_DUTY: shadow_nxt[k].duty = cfg_data[15:0];
                    default:   ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow   <= {N_CH{CFG_RST}};
            active   <= {N_CH{CFG_RST}};
            vld_pipe <= {{STAGES{1'b0}}, 1'b1};
        end else begin
            shadow   <= shadow_nxt;
            if (commit) active <= shadow_nxt;
            vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
        end
    end

    assign dac_valid = vld_pipe[STAGES];
    assign dac_clk   = clk;
    assign dac_wr    = ~clk;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [PHASE_W-1:0]      acc;
        logic [15:0]             lfsr, p;
        logic [LUT_AW-1:0]       lut_addr;
        logic [DAC_W-2:0]        lut_q;
        logic [DAC_W-1:0]        raw, s1_raw, y_sat, dac_q;
        logic                    s1_sin, s1_neg;
        logic [7:0]              s1_gain;
        logic signed [DAC_W-1:0] lut_s, s1_s;
        logic signed [8:0]       gain_s;
        logic signed [DAC_W+8:0] prod, y;

        always_ff @(posedge clk) begin
            if (rst) begin
                acc  <= '0;
                lfsr <= LFSR_SEED + 16'(k);
            end else begin
                acc  <= (commit && sync) ? '0 : acc + active[k].ftw[PHASE_W-1:0];
                lfsr <= lfsr_next(lfsr);
            end
        end

        assign p        = acc[PHASE_W-1 -: 16] + active[k].poff;
        assign lut_addr = p[14] ? ~p[13 -: LUT_AW] : p[13 -: LUT_AW];

        always_comb begin
            raw = MID;
            case (active[k].mode)
                MODE_SAW:   raw = p[15 -: DAC_W];
                MODE_TRI:   raw = p[15] ? ~p[14 -: DAC_W] : p[14 -: DAC_W];
                MODE_SQR:   raw = (p < active[k].duty) ? '1 : '0;
                MODE_NOISE: raw = lfsr[15 -: DAC_W];
                default:    raw = MID;
            endcase
        end

        sin_lut #(.LUT_AW(LUT_AW), .DAC_W(DAC_W)) u_lut (
            .clk  (clk),
            .addr (lut_addr),
            .data (lut_q)
        );

        // S1: raw sample, LUT read and gain travel together so a commit
        // never mixes old and new settings within one sample.
        always_ff @(posedge clk) begin
            if (rst) begin
                s1_raw  <= MID;
                s1_sin  <= 1'b0;
                s1_neg  <= 1'b0;
                s1_gain <= GAIN_UNITY;
            end else begin
                s1_raw  <= raw;
                s1_sin  <= (active[k].mode == MODE_SIN);
                s1_neg  <= p[15];
                s1_gain <= active[k].gain;
            end
        end

        assign lut_s  = signed'({1'b0, lut_q});
        assign s1_s   = s1_sin ? (s1_neg ? -lut_s : lut_s)
                               : signed'({~s1_raw[DAC_W-1], s1_raw[DAC_W-2:0]});
        assign gain_s = signed'({1'b0, s1_gain});

        always_ff @(posedge clk) begin
            if (rst) prod <= '0;
            else     prod <= (DAC_W+9)'(s1_s) * (DAC_W+9)'(gain_s);
        end

        assign y = prod >>> 7;

        always_comb begin
            if (y > Y_MAX)      y_sat = Y_MAX[DAC_W-1:0];
            else if (y < Y_MIN) y_sat = Y_MIN[DAC_W-1:0];
            else                y_sat = y[DAC_W-1:0];
        end

        always_ff @(posedge clk) begin
            if (rst) dac_q <= MID;
            else     dac_q <= {~y_sat[DAC_W-1], y_sat[DAC_W-2:0]};
        end

        assign dac_data[k*DAC_W +: DAC_W] = dac_q;
    end

endmodule

// File: tb/tb_awg_multich.sv
// Scoreboard bench for awg_multich: a behavioural model predicts every
// sample at the accumulator edge; the DUT output is compared three edges on.
module tb_awg_multich;

    localparam int NCH = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cfg_we = 1'b0;
    logic [2:0]      cfg_ch = '0;
    logic [2:0]      cfg_addr = '0;
    logic [31:0]     cfg_data = '0;
    logic            commit = 1'b0;
    logic            sync = 1'b0;
    logic [NCH*14-1:0] dac_data;
    logic            dac_valid, dac_clk, dac_wr;

    awg_multich #(.N_CH(NCH), .DAC_W(14), .PHASE_W(32), .LUT_AW(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .commit    (commit),
        .sync      (sync),
        .dac_data  (dac_data),
        .dac_valid (dac_valid),
        .dac_clk   (dac_clk),
        .dac_wr    (dac_wr)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit [2:0]  mode;
        bit [31:0] ftw;
        bit [15:0] poff;
        bit [7:0]  gain;
        bit [15:0] duty;
    } cfg_t;

    typedef struct packed {
        logic [NCH-1:0][15:0] v;
        logic [NCH-1:0][3:0]  t;
    } exp_t;

    cfg_t      sh [NCH];
    cfg_t      ac [NCH];
    bit [31:0] m_acc [NCH];
    bit [15:0] m_lfsr [NCH];
    exp_t      q [$];
    int        n_chk = 0;
    int        n_err = 0;

    task automatic chk(input string tag, input int got, input int exp, input int tol = 0);
        n_chk++;
        if (got > exp + tol || got < exp - tol) begin
            n_err++;
            $display("FAIL %s got %0d want %0d (tol %0d) at %0t", tag, got, exp, tol, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < NCH; k++) begin
            sh[k]     = '{mode: 3'd0, ftw: 32'd0, poff: 16'd0, gain: 8'd128, duty: 16'h8000};
            ac[k]     = sh[k];
            m_acc[k]  = 32'd0;
            m_lfsr[k] = 16'hACE1 + 16'(k);
        end
    endfunction

    function automatic int expect_val(input int k, output int tol);
        bit [15:0] p;
        bit [13:0] t1, t2;
        int raw, s, y;
        real ang;
        p   = m_acc[k][31:16] + ac[k].poff;
        tol = 0;
        case (ac[k].mode)
            3'd1: raw = int'(p[15:2]);
            3'd2: begin
                t1  = p[14:1];
                t2  = ~t1;
                raw = p[15] ? int'(t2) : int'(t1);
            end
            3'd3: raw = (p < ac[k].duty) ? 16383 : 0;
            3'd4: begin
                ang = 2.0 * 3.14159265358979 * (real'(p >> 4) + 0.5) / 4096.0;
                raw = 8192 + $rtoi($floor(8191.0 * $sin(ang) + 0.5));
                tol = 2;
            end
            3'd5: raw = int'(m_lfsr[k][15:2]);
            default: raw = 8192;
        endcase
        s = raw - 8192;
        y = (s * int'(ac[k].gain)) >>> 7;
        if (y > 8191)  y = 8191;
        if (y < -8192) y = -8192;
        return y + 8192;
    endfunction

    // Mirrors what the DUT registers at this edge, then queues the sample
    // that the new accumulator value will produce.
    function automatic void model_edge();
        exp_t e;
        int   tl;
        if (rst) begin
            model_reset();
            q.delete();
            for (int k = 0; k < NCH; k++) begin
                e.v[k] = 16'd8192;
                e.t[k] = 4'd0;
            end
            q.push_back(e);
            return;
        end
        for (int k = 0; k < NCH; k++) begin
            m_acc[k]  = (commit && sync) ? 32'd0 : m_acc[k] + ac[k].ftw;
            m_lfsr[k] = {m_lfsr[k][14:0],
                         m_lfsr[k][15] ^ m_lfsr[k][13] ^ m_lfsr[k][12] ^ m_lfsr[k][10]};
        end
        if (cfg_we && int'(cfg_ch) < NCH) begin
            case (cfg_addr)
                3'd0: sh[cfg_ch].mode = cfg_data[2:0];
                3'd1: sh[cfg_ch].ftw  = cfg_data;
                3'd2: sh[cfg_ch].poff = cfg_data[15:0];
                3'd3: sh[cfg_ch].gain = cfg_data[7:0];
                3'd4: sh[cfg_ch].duty = cfg_data[15:0];
                default: ;
            endcase
        end
        if (commit)
            for (int k = 0; k < NCH; k++) ac[k] = sh[k];
        for (int k = 0; k < NCH; k++) begin
            e.v[k] = 16'(expect_val(k, tl));
            e.t[k] = 4'(tl);
        end
        q.push_back(e);
    endfunction

    task automatic tick();
        exp_t e;
        @(posedge clk);
        model_edge();
        #1;
        if (q.size() > 3) begin
            e = q.pop_front();
            chk("valid", int'(dac_valid), 1);
            for (int k = 0; k < NCH; k++)
                chk($sformatf("ch%0d", k), int'(dac_data[k*14 +: 14]), int'(e.v[k]), int'(e.t[k]));
        end else begin
            chk("valid_lo", int'(dac_valid), 0);
            for (int k = 0; k < NCH; k++)
                chk($sformatf("mid%0d", k), int'(dac_data[k*14 +: 14]), 8192);
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input int ch, input int addr, input int data);
        cfg_we   = 1'b1;
        cfg_ch   = 3'(ch);
        cfg_addr = 3'(addr);
        cfg_data = 32'(data);
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic cmt(input bit s);
        commit = 1'b1;
        sync   = s;
        tick();
        commit = 1'b0;
        sync   = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        run(3);
        rst = 1'b0;
        run(6);

        // saw on ch0, 16 LSB per sample, wraps every 1024 cycles
        wr(0, 1, 1 << 22);
        wr(0, 0, 1);
        cmt(1'b1);
        run(1100);

        // square on ch1 at 25% duty, then half gain
        wr(1, 4, 32'h4000);
        wr(1, 1, 1 << 24);
        wr(1, 0, 3);
        cmt(1'b0);
        run(300);
        wr(1, 3, 64);
        cmt(1'b0);
        run(260);

        // triangle on ch1, saw on ch0 with gain saturating both rails
        wr(1, 3, 128);
        wr(1, 0, 2);
        wr(0, 3, 255);
        cmt(1'b0);
        run(1030);

        // shadow write without commit leaves the active waveform alone
        wr(0, 1, 1 << 20);
        wr(0, 3, 128);
        run(50);
        // write and commit on the same edge: mode 4 lands with the commit
        cfg_we   = 1'b1;
        cfg_ch   = 3'd0;
        cfg_addr = 3'd0;
        cfg_data = 32'd4;
        cmt(1'b0);
        cfg_we   = 1'b0;
        run(100);

        // two sines, ch1 a quarter period ahead, re-aligned by sync
        wr(0, 1, 1 << 24);
        wr(1, 1, 1 << 24);
        wr(0, 2, 0);
        wr(1, 2, 32'h4000);
        wr(1, 0, 4);
        cmt(1'b1);
        run(330);

        // noise on ch1, reserved mode on ch0, out-of-range channel ignored
        wr(1, 0, 5);
        wr(0, 0, 6);
        wr(5, 0, 1);
        wr(7, 3, 0);
        cmt(1'b0);
        run(60);

        // mid-run reset beats a simultaneous commit
        rst = 1'b1;
        cfg_we   = 1'b1;
        cfg_ch   = 3'd0;
        cfg_addr = 3'd0;
        cfg_data = 32'd1;
        commit   = 1'b1;
        run(2);
        cfg_we = 1'b0;
        commit = 1'b0;
        rst    = 1'b0;
        run(8);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/awg_multich.md
# awg_multich

Parametrised multi-channel DDS waveform generator; successor to the single-channel fixed-mode signal generator. It provides N_CH independent channels, each with a 32-bit phase accumulator, per-channel waveform mode, gain, phase offset and square duty. Configuration is double-buffered and applied atomically on a commit strobe. It sits between the front-panel/state controller and the DAC pins, and drives offset-binary samples every clock.

## Interface
- N_CH, 2, channel count (1..8)
- DAC_W, 14, DAC sample width, offset-binary
- PHASE_W, 32, accumulator / tuning-word width
- LUT_AW, 10, quarter-wave sine table address width
- clk  in  1  sample clock; also forwarded to DAC
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  write strobe to shadow registers
- cfg_ch  in  3  target channel (values ≥ N_CH ignored)
- cfg_addr  in  3  0 mode[2:0], 1 ftw[PHASE_W-1:0], 2 poff[15:0], 3 gain[7:0], 4 duty[15:0]; others ignored
- cfg_data  in  32  write data, LSB-aligned
- commit  in  1  copy all shadows to active, all channels, same edge
- sync  in  1  with commit: clear all accumulators
- dac_data  out  N_CH*DAC_W  channel k at [k*DAC_W +: DAC_W]
- dac_valid  out  1  high once pipeline is filled after reset
- dac_clk  out  1  = clk;  dac_wr  out  1  = ~clk

## Operation
- Modes: 0 off (mid-scale), 1 saw, 2 triangle, 3 square, 4 sine, 5 noise; 6/7 behave as 0.
- Accumulator: acc <= (commit & sync) ? 0 : acc + ftw_active, modulo 2^PHASE_W. Wrap is silent.
- Phase p = acc[PHASE_W-1 -: 16] + poff, modulo 2^16.
- Saw: raw = p[15 -: DAC_W]. Triangle: raw = p[15] ? ~p[14 -: DAC_W] : p[14 -: DAC_W]. Square: raw = (p < duty) ? all-ones : 0; duty 0 gives constant 0. Sine: quarter-wave LUT indexed by p[13 -: LUT_AW], mirrored on p[14], negated about mid-scale on p[15]. Noise: per-channel 16-bit Fibonacci LFSR (taps 16,14,13,11), seed 0xACE1 + k, advances every cycle; raw = top DAC_W bits.
- Gain: s = raw − 2^(DAC_W−1) (signed), y = (s × gain) >>> 7. Unity at 128; saturate y to [−2^(DAC_W−1), 2^(DAC_W−1)−1]; output = y + 2^(DAC_W−1).
- A write and a commit in the same cycle: the written value is included in the commit.
- Writes do not disturb the active set until commit.
- Reset values: acc 0; shadow/active: mode 0, ftw 0, poff 0, gain 128, duty 0x8000; LFSRs at seed; dac_data all channels 2^(DAC_W−1) (8192 for DAC_W=14); dac_valid 0.
- rst mid-operation overrides cfg_we/commit in that cycle.

## Timing
- Pipeline: S1 phase→raw (LUT registered), S2 signed multiply, S3 saturate/offset → dac_data. The accumulator value of edge n appears on dac_data at edge n+3.
- Commit at edge n: the active regs update at n. The new mode/gain/poff are reflected on dac_data from edge n+3. The new ftw first advances the accumulator at edge n+1.
- dac_valid rises at the 3rd edge after rst deasserts and stays high. dac_data holds mid-scale until then.
- All channels are phase-aligned: same commit/sync edge, same latency.

## Structure
- Package awg_pkg: mode encodings, cfg_addr map, reset constants (GAIN_UNITY=128, DUTY_RST=16'h8000), LFSR taps/seed.
- Sub-module sin_lut: quarter-wave ROM, 2^LUT_AW × (DAC_W−1) entries, one-cycle registered read, instanced per channel.
- Per-channel logic is a generate loop. Config decode is shared.

## Test plan
- Reset: rst 3 cycles then release → every dac_data = 8192 and dac_valid = 0 for 2 cycles, then 1 on the 3rd edge.
- Saw ch0: ftw = 2^22, mode 1, commit+sync → dac_data ch0 increments by 16 per cycle from 0, wraps 16368→0 every 1024 cycles. First sample arrives 3 cycles after commit.
- Square ch1: mode 3, duty 0x4000, ftw 2^24 → 64 cycles 16383 then 192 cycles 0. Gain 64 gives 12287/4096.
- Gain saturation: saw, gain 255 → output clamps at 0 and 16383 with no wrap.
- Shadow isolation: write ftw without commit → ch0 waveform unchanged. A commit with a simultaneous write of mode 4 switches to sine 3 cycles later.
- Sync alignment: ch0/ch1 sine, same ftw, poff 0 vs 0x4000 → ch1 leads ch0 by a quarter period. Mid-run rst returns both to 8192.
